// File: rtl/mem_arbiter_pkg.sv
// Shared types for the RAM arbiter: FSM state encodings, requester ownership, defaults.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF     = 20;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_SPLIT = 1'b1
    } rd_state_t;

    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_SPLIT = 1'b1
    } wr_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_EU = 1'b1
    } owner_t;

    function automatic logic [15:0] zext_byte(input logic [7:0] b);
        return {8'h00, b};
    endfunction

endpackage

// File: rtl/mem_split_fsm.sv
// Sequences one RAM port: single cycle for aligned/byte access, lo byte then hi byte (addr+1) for odd words.
// Start is ignored while the hi-byte cycle is in progress; the owner must not grant then.
module mem_split_fsm #(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_split,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_busy,
    output logic              o_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_lo,
    output logic              o_hi,
    output logic              o_last
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_HI   = 1'b1;

    logic              r_state;
    logic              w_state_nxt;
    logic [ADDR_W-1:0] r_hi_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Increment wraps naturally at the top of the address space.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi_addr <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_hi_addr <= i_addr + ADDR_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start && i_split) w_state_nxt = S_HI;
            S_HI:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_en   = 1'b0;
        o_addr = i_addr;
        o_lo   = 1'b0;
        o_hi   = 1'b0;
        o_last = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_en   = i_start;
                o_lo   = i_start & i_split;
                o_last = i_start & ~i_split;
            end
            S_HI: begin
                o_en   = 1'b1;
                o_addr = r_hi_addr;
                o_hi   = 1'b1;
                o_last = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_busy = r_state;

endmodule

// File: rtl/mem_arbiter.sv
// Shares a 1R/1W byte RAM between fetch (read-only) and EU; read data 1 cycle (odd word 2), write done 1 cycle (odd word 2).
// Requests are held until gnt; EU read wins the read port unless fetch has lost STARVE_MAX times in a row.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [15:0]       if_rdata,
    input  logic              eu_req,
    input  logic              eu_we,
    input  logic              eu_w,
    input  logic [ADDR_W-1:0] eu_addr,
    input  logic [15:0]       eu_wdata,
    output logic              eu_gnt,
    output logic              eu_rvalid,
    output logic [15:0]       eu_rdata,
    output logic              eu_wdone,
    output logic              ram_rd_en,
    output logic              ram_rd_we,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [15:0]       ram_rd_data,
    output logic              ram_wr_en,
    output logic              ram_wr_we,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [15:0]       ram_wr_data
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    rd_state_t         w_rd_state;
    wr_state_t         w_wr_state;
    logic              w_rd_busy;
    logic              w_wr_busy;

    owner_t            r_rd_owner;
    logic [CNT_W-1:0]  r_starve;
    logic [7:0]        r_rd_lo;
    logic [7:0]        r_wr_hi;
    logic              r_if_rvalid;
    logic              r_eu_rvalid;
    logic              r_eu_wdone;
    logic [15:0]       r_if_rdata;
    logic [15:0]       r_eu_rdata;

    logic              w_rd_idle;
    logic              w_eu_blocked;
    logic              w_if_rd_req;
    logic              w_eu_rd_req;
    logic              w_starved;
    logic              w_if_rd_gnt;
    logic              w_eu_rd_gnt;
    logic              w_eu_wr_gnt;

    logic              w_rd_start;
    owner_t            w_rd_own;
    logic [ADDR_W-1:0] w_rd_addr_in;
    logic              w_rd_word;
    logic              w_rd_split_in;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_lo;
    logic              w_rd_hi;
    logic              w_rd_last;
    owner_t            w_cpl_owner;
    logic [15:0]       w_cpl_data;

    logic              w_wr_split_in;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_wr_lo;
    logic              w_wr_hi;
    logic              w_wr_last;

    assign w_rd_state = rd_state_t'(w_rd_busy);
    assign w_wr_state = wr_state_t'(w_wr_busy);

    // ---------------- arbitration ----------------
    // EU has one transaction in flight: block it during its own split read or any split write.
    assign w_rd_idle    = (w_rd_state == RD_IDLE);
    assign w_eu_blocked = ((w_rd_state == RD_SPLIT) && (r_rd_owner == OWN_EU))
                        || (w_wr_state == WR_SPLIT);
    assign w_if_rd_req  = ~rst & if_req & w_rd_idle;
    assign w_eu_rd_req  = ~rst & eu_req & ~eu_we & ~w_eu_blocked & w_rd_idle;
    assign w_starved    = (r_starve == CNT_W'(STARVE_MAX));
    assign w_eu_rd_gnt  = w_eu_rd_req & ~(w_starved & w_if_rd_req);
    assign w_if_rd_gnt  = w_if_rd_req & ~w_eu_rd_gnt;
    assign w_eu_wr_gnt  = ~rst & eu_req & eu_we & ~w_eu_blocked;

    assign if_gnt = w_if_rd_gnt;
    assign eu_gnt = w_eu_rd_gnt | w_eu_wr_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_if_rd_gnt) begin
            r_starve <= '0;
        end else if (w_if_rd_req && !w_starved) begin
            r_starve <= r_starve + CNT_W'(1);
        end
    end

    // ---------------- read port ----------------
    assign w_rd_start    = w_if_rd_gnt | w_eu_rd_gnt;
    assign w_rd_own      = w_eu_rd_gnt ? OWN_EU : OWN_IF;
    assign w_rd_addr_in  = w_eu_rd_gnt ? eu_addr : if_addr;
    assign w_rd_word     = w_eu_rd_gnt ? eu_w : 1'b1;
    assign w_rd_split_in = w_rd_word & w_rd_addr_in[0];

    mem_split_fsm #(.ADDR_W(ADDR_W)) u_rd_fsm (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_rd_start),
        .i_split (w_rd_split_in),
        .i_addr  (w_rd_addr_in),
        .o_busy  (w_rd_busy),
        .o_en    (w_rd_en),
        .o_addr  (w_rd_addr),
        .o_lo    (w_rd_lo),
        .o_hi    (w_rd_hi),
        .o_last  (w_rd_last)
    );

    assign ram_rd_en   = w_rd_en & ~rst;
    assign ram_rd_we   = w_rd_start & w_rd_word & ~w_rd_split_in;
    assign ram_rd_addr = w_rd_addr;
    assign w_cpl_owner = w_rd_hi ? r_rd_owner : w_rd_own;

    // Byte-mode RAM reads leave [15:8] undriven, so only the low lane is ever used there.
    always_comb begin
        w_cpl_data = zext_byte(ram_rd_data[7:0]);
        if (w_rd_hi) begin
            w_cpl_data = {ram_rd_data[7:0], r_rd_lo};
        end else if (ram_rd_we) begin
            w_cpl_data = ram_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rvalid <= 1'b0;
            r_eu_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_eu_rdata  <= '0;
            r_rd_lo     <= '0;
            r_rd_owner  <= OWN_IF;
        end else begin
            r_if_rvalid <= w_rd_last && (w_cpl_owner == OWN_IF);
            r_eu_rvalid <= w_rd_last && (w_cpl_owner == OWN_EU);
            if (w_rd_last && w_cpl_owner == OWN_IF) r_if_rdata <= w_cpl_data;
            if (w_rd_last && w_cpl_owner == OWN_EU) r_eu_rdata <= w_cpl_data;
            if (w_rd_lo) begin
                r_rd_lo    <= ram_rd_data[7:0];
                r_rd_owner <= w_rd_own;
            end
        end
    end

    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign eu_rvalid = r_eu_rvalid;
    assign eu_rdata  = r_eu_rdata;

    // ---------------- write port ----------------
    assign w_wr_split_in = eu_w & eu_addr[0];

    mem_split_fsm #(.ADDR_W(ADDR_W)) u_wr_fsm (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_eu_wr_gnt),
        .i_split (w_wr_split_in),
        .i_addr  (eu_addr),
        .o_busy  (w_wr_busy),
        .o_en    (w_wr_en),
        .o_addr  (w_wr_addr),
        .o_lo    (w_wr_lo),
        .o_hi    (w_wr_hi),
        .o_last  (w_wr_last)
    );

    assign ram_wr_en   = w_wr_en & ~rst;
    assign ram_wr_we   = w_eu_wr_gnt & eu_w & ~eu_addr[0];
    assign ram_wr_addr = w_wr_addr;

    always_comb begin
        ram_wr_data = zext_byte(eu_wdata[7:0]);
        if (w_wr_hi) begin
            ram_wr_data = zext_byte(r_wr_hi);
        end else if (ram_wr_we) begin
            ram_wr_data = eu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_hi    <= '0;
            r_eu_wdone <= 1'b0;
        end else begin
            r_eu_wdone <= w_wr_last;
            if (w_wr_lo) r_wr_hi <= eu_wdata[15:8];
        end
    end

    assign eu_wdone = r_eu_wdone;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model (byte-mode reads drive 8'hEE on the upper lane).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [19:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [15:0] if_rdata;
    logic        eu_req, eu_we, eu_w;
    logic [19:0] eu_addr;
    logic [15:0] eu_wdata;
    logic        eu_gnt, eu_rvalid, eu_wdone;
    logic [15:0] eu_rdata;
    logic        ram_rd_en, ram_rd_we, ram_wr_en, ram_wr_we;
    logic [19:0] ram_rd_addr, ram_wr_addr;
    logic [15:0] ram_rd_data, ram_wr_data;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [0:1048575];
    logic        pl_en = 1'b0;
    logic [19:0] pl_addr = '0;
    logic [7:0]  pl_dat = '0;
    logic [19:0] rd_addr_p1;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .eu_req(eu_req), .eu_we(eu_we), .eu_w(eu_w), .eu_addr(eu_addr),
        .eu_wdata(eu_wdata), .eu_gnt(eu_gnt), .eu_rvalid(eu_rvalid),
        .eu_rdata(eu_rdata), .eu_wdone(eu_wdone),
        .ram_rd_en(ram_rd_en), .ram_rd_we(ram_rd_we), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .ram_wr_en(ram_wr_en), .ram_wr_we(ram_wr_we), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data)
    );

    assign rd_addr_p1  = ram_rd_addr + 20'd1;
    assign ram_rd_data = ram_rd_we ? {mem[rd_addr_p1], mem[ram_rd_addr]} : {8'hEE, mem[ram_rd_addr]};

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_dat;
        end else if (ram_wr_en) begin
            mem[ram_wr_addr] <= ram_wr_data[7:0];
            if (ram_wr_we) mem[ram_wr_addr + 20'd1] <= ram_wr_data[15:8];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [19:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_dat = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = '0; eu_req = 0; eu_we = 0; eu_w = 0; eu_addr = '0; eu_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step(); step();
        if_req = 1; if_addr = 20'h00100; eu_req = 1; eu_we = 1; eu_w = 1; eu_addr = 20'h00010;
        @(negedge clk);
        checks++; if (if_gnt !== 1'b0) begin failures++; $display("FAIL rst_if_gnt got=%b exp=0", if_gnt); end
        checks++; if (eu_gnt !== 1'b0) begin failures++; $display("FAIL rst_eu_gnt got=%b exp=0", eu_gnt); end
        checks++; if (ram_rd_en !== 1'b0 || ram_wr_en !== 1'b0) begin failures++; $display("FAIL rst_ram_en got=%b%b exp=00", ram_rd_en, ram_wr_en); end
        checks++; if ({if_rvalid, eu_rvalid, eu_wdone} !== 3'b000) begin failures++; $display("FAIL rst_strobes got=%b exp=000", {if_rvalid, eu_rvalid, eu_wdone}); end
        checks++; if (if_rdata !== 16'h0 || eu_rdata !== 16'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0000/0000", if_rdata, eu_rdata); end
        step();
        idle_inputs();
        rst = 0;
        step();
    endtask

    task automatic test_if_aligned();
        if_req = 1; if_addr = 20'h00100;
        @(negedge clk);
        checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL ifa_gnt got=%b exp=1", if_gnt); end
        checks++; if ({ram_rd_en, ram_rd_we, ram_rd_addr} !== {2'b11, 20'h00100}) begin failures++; $display("FAIL ifa_ram got=%b%b %h exp=11 00100", ram_rd_en, ram_rd_we, ram_rd_addr); end
        step();
        if_req = 0;
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b1) begin failures++; $display("FAIL ifa_rvalid got=%b exp=1", if_rvalid); end
        checks++; if (if_rdata !== 16'h1234) begin failures++; $display("FAIL ifa_rdata got=%h exp=1234", if_rdata); end
        checks++; if (ram_rd_en !== 1'b0) begin failures++; $display("FAIL ifa_idle_en got=%b exp=0", ram_rd_en); end
        step();
    endtask

    task automatic test_if_odd_wrap();
        if_req = 1; if_addr = 20'hFFFFF;
        @(negedge clk);
        checks++; if ({if_gnt, ram_rd_en, ram_rd_we, ram_rd_addr} !== {3'b110, 20'hFFFFF}) begin failures++; $display("FAIL ifo_lo got=%b%b%b %h exp=110 fffff", if_gnt, ram_rd_en, ram_rd_we, ram_rd_addr); end
        step();
        if_addr = 20'h00100;    // next fetch already pending during the split
        @(negedge clk);
        checks++; if ({if_gnt, ram_rd_en, ram_rd_we, ram_rd_addr} !== {3'b010, 20'h00000}) begin failures++; $display("FAIL ifo_hi got=%b%b%b %h exp=010 00000", if_gnt, ram_rd_en, ram_rd_we, ram_rd_addr); end
        checks++; if (if_rvalid !== 1'b0) begin failures++; $display("FAIL ifo_early_rvalid got=%b exp=0", if_rvalid); end
        step();
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 16'hABCD) begin failures++; $display("FAIL ifo_data got=%b %h exp=1 abcd", if_rvalid, if_rdata); end
        checks++; if (if_gnt !== 1'b1 || ram_rd_addr !== 20'h00100) begin failures++; $display("FAIL ifo_regrant got=%b %h exp=1 00100", if_gnt, ram_rd_addr); end
        step();
        if_req = 0;
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 16'h1234) begin failures++; $display("FAIL ifo_next got=%b %h exp=1 1234", if_rvalid, if_rdata); end
        step();
    endtask

    task automatic test_eu_byte();
        eu_req = 1; eu_we = 0; eu_w = 0; eu_addr = 20'h00301;
        @(negedge clk);
        checks++; if ({eu_gnt, ram_rd_en, ram_rd_we, ram_rd_addr} !== {3'b110, 20'h00301}) begin failures++; $display("FAIL eub_req got=%b%b%b %h exp=110 00301", eu_gnt, ram_rd_en, ram_rd_we, ram_rd_addr); end
        step();
        eu_req = 0;
        @(negedge clk);
        checks++; if (eu_rvalid !== 1'b1 || eu_rdata !== 16'h007F) begin failures++; $display("FAIL eub_data got=%b %h exp=1 007f", eu_rvalid, eu_rdata); end
        step();
    endtask

    task automatic test_eu_write_split();
        eu_req = 1; eu_we = 1; eu_w = 1; eu_addr = 20'h00201; eu_wdata = 16'hBEEF;
        if_req = 1; if_addr = 20'h00100;
        @(negedge clk);
        checks++; if (eu_gnt !== 1'b1 || if_gnt !== 1'b1) begin failures++; $display("FAIL euw_gnts got=%b%b exp=11", eu_gnt, if_gnt); end
        checks++; if ({ram_wr_en, ram_wr_we, ram_wr_addr, ram_wr_data[7:0]} !== {2'b10, 20'h00201, 8'hEF}) begin failures++; $display("FAIL euw_lo got=%b%b %h %h exp=10 00201 ef", ram_wr_en, ram_wr_we, ram_wr_addr, ram_wr_data[7:0]); end
        step();
        if_req = 0;
        eu_we = 0; eu_w = 0; eu_addr = 20'h00202; eu_wdata = 16'h0000;
        @(negedge clk);
        checks++; if ({ram_wr_en, ram_wr_we, ram_wr_addr, ram_wr_data[7:0]} !== {2'b10, 20'h00202, 8'hBE}) begin failures++; $display("FAIL euw_hi got=%b%b %h %h exp=10 00202 be", ram_wr_en, ram_wr_we, ram_wr_addr, ram_wr_data[7:0]); end
        checks++; if (eu_wdone !== 1'b0 || eu_gnt !== 1'b0) begin failures++; $display("FAIL euw_busy got=wdone%b gnt%b exp=0 0", eu_wdone, eu_gnt); end
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 16'h1234) begin failures++; $display("FAIL euw_if_data got=%b %h exp=1 1234", if_rvalid, if_rdata); end
        step();
        @(negedge clk);
        checks++; if (eu_wdone !== 1'b1 || ram_wr_en !== 1'b0) begin failures++; $display("FAIL euw_done got=%b en%b exp=1 0", eu_wdone, ram_wr_en); end
        checks++; if (mem[20'h00201] !== 8'hEF || mem[20'h00202] !== 8'hBE) begin failures++; $display("FAIL euw_mem got=%h %h exp=ef be", mem[20'h00201], mem[20'h00202]); end
        checks++; if (eu_gnt !== 1'b1) begin failures++; $display("FAIL euw_regrant got=%b exp=1", eu_gnt); end
        step();
        eu_req = 0;
        @(negedge clk);
        checks++; if (eu_rvalid !== 1'b1 || eu_rdata !== 16'h00BE) begin failures++; $display("FAIL euw_readback got=%b %h exp=1 00be", eu_rvalid, eu_rdata); end
        step();
    endtask

    task automatic test_starve();
        for (int round = 0; round < 2; round++) begin
            if_req = 1; if_addr = 20'h00100;
            eu_req = 1; eu_we = 0; eu_w = 1; eu_addr = 20'h00400;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                checks++;
                if (c < 4 && (eu_gnt !== 1'b1 || if_gnt !== 1'b0)) begin failures++; $display("FAIL stv_eu_win r%0d c%0d got=eu%b if%b exp=eu1 if0", round, c, eu_gnt, if_gnt); end
                if (c == 4 && (eu_gnt !== 1'b0 || if_gnt !== 1'b1)) begin failures++; $display("FAIL stv_if_win r%0d got=eu%b if%b exp=eu0 if1", round, eu_gnt, if_gnt); end
                if (c > 0) begin
                    checks++; if (eu_rvalid !== 1'b1 || eu_rdata !== 16'h2211) begin failures++; $display("FAIL stv_eu_data r%0d c%0d got=%b %h exp=1 2211", round, c, eu_rvalid, eu_rdata); end
                end
                step();
            end
            if_req = 0;
            @(negedge clk);
            checks++; if (if_rvalid !== 1'b1 || if_rdata !== 16'h1234 || eu_gnt !== 1'b1) begin failures++; $display("FAIL stv_after r%0d got=%b %h eu%b exp=1 1234 eu1", round, if_rvalid, if_rdata, eu_gnt); end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_split();
        if_req = 1; if_addr = 20'h00101;
        @(negedge clk);
        checks++; if (if_gnt !== 1'b1 || ram_rd_we !== 1'b0) begin failures++; $display("FAIL rss_gnt got=%b we%b exp=1 0", if_gnt, ram_rd_we); end
        step();
        if_req = 0; rst = 1;
        @(negedge clk);
        checks++; if (ram_rd_en !== 1'b0 || if_gnt !== 1'b0) begin failures++; $display("FAIL rss_in_rst got=en%b gnt%b exp=0 0", ram_rd_en, if_gnt); end
        step();
        rst = 0;
        @(negedge clk);
        checks++; if ({if_rvalid, eu_rvalid, eu_wdone, ram_rd_en, ram_wr_en} !== 5'b0) begin failures++; $display("FAIL rss_strobes got=%b exp=00000", {if_rvalid, eu_rvalid, eu_wdone, ram_rd_en, ram_wr_en}); end
        checks++; if (if_rdata !== 16'h0 || eu_rdata !== 16'h0) begin failures++; $display("FAIL rss_rdata got=%h/%h exp=0000/0000", if_rdata, eu_rdata); end
        step();
        if_req = 1; if_addr = 20'h00100;
        @(negedge clk);
        checks++; if ({if_gnt, ram_rd_we, ram_rd_addr} !== {2'b11, 20'h00100}) begin failures++; $display("FAIL rss_fresh got=%b%b %h exp=11 00100", if_gnt, ram_rd_we, ram_rd_addr); end
        step();
        if_req = 0;
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 16'h1234) begin failures++; $display("FAIL rss_data got=%b %h exp=1 1234", if_rvalid, if_rdata); end
        step();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        preload(20'h00100, 8'h34);
        preload(20'h00101, 8'h12);
        preload(20'hFFFFF, 8'hCD);
        preload(20'h00000, 8'hAB);
        preload(20'h00301, 8'h7F);
        preload(20'h00400, 8'h11);
        preload(20'h00401, 8'h22);
        test_reset();
        test_if_aligned();
        test_if_odd_wrap();
        test_eu_byte();
        test_eu_write_split();
        test_starve();
        test_reset_split();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
